write_back_buffered: RTL and testbench

Parametrised successor to the single-cycle write-back stage. It selects the result (memory or ALU), applies load-size and sign/zero extension, and queues completed register writes in a DEPTH-entry in-order buffer. The buffer drains to a register-file write port that can refuse writes via ip_rf_ready. Provides a forwarding lookup over pending writes and back-pressures the MEM stage when full.

---
 rtl/write_back_buffered.sv | 116 +++++++++++
 tb/tb_write_back_buffered.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/write_back_buffered.sv
// Write-back stage: selects/extends the result and queues register writes in an in-order buffer with forwarding.
// Accepted writes reach the head one cycle later; op_stall holds MEM while full, and ip_rf_ready drains the head.
module write_back_buffered #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 5,
  parameter int DEPTH            = 4,
  parameter int ZERO_REG_DISCARD = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ip_valid,
  input  logic                     ip_MemtoReg,
  input  logic                     ip_RegWrite,
  input  logic [1:0]               ip_load_size,
  input  logic                     ip_load_signed,
  input  logic [DATA_W-1:0]        ip_memory_data,
  input  logic [DATA_W-1:0]        ip_ALU_result,
  input  logic [ADDR_W-1:0]        ip_dest_reg,
  output logic                     op_stall,
  input  logic                     ip_rf_ready,
  output logic                     op_RegWrite,
  output logic [DATA_W-1:0]        op_write_data,
  output logic [ADDR_W-1:0]        op_dest_reg,
  input  logic [ADDR_W-1:0]        ip_fwd_reg,
  output logic                     op_fwd_hit,
  output logic [DATA_W-1:0]        op_fwd_data,
  output logic [$clog2(DEPTH):0]   op_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_dest [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_full;
  logic              w_nonempty;
  logic              w_enq;
  logic              w_deq;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [PW-1:0]     w_idx;

  // Fill the upper bits by loop so DATA_W == 16 needs no zero-width replication.
  always_comb begin
    w_wb_data = ip_ALU_result;
    if (ip_MemtoReg) begin
      w_wb_data = ip_memory_data;
      case (ip_load_size)
        2'b01: for (int b = 16; b < DATA_W; b++) w_wb_data[b] = ip_load_signed & ip_memory_data[15];
        2'b10: for (int b = 8; b < DATA_W; b++) w_wb_data[b] = ip_load_signed & ip_memory_data[7];
        default: ;
      endcase
    end
  end

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_enq      = ip_valid & ip_RegWrite & ~w_full &
                      ~((ZERO_REG_DISCARD != 0) && (ip_dest_reg == '0));
  assign w_deq      = w_nonempty & ip_rf_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Enqueue and dequeue never share a slot: that would need empty and full at once.
      if (w_enq) begin
        r_data[r_wr_ptr] <= w_wb_data;
        r_dest[r_wr_ptr] <= ip_dest_reg;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if (r_vld[w_idx] && (r_dest[w_idx] == ip_fwd_reg) && (ip_fwd_reg != '0)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end

  assign op_stall      = w_full & ~reset;
  assign op_RegWrite   = w_nonempty & ~reset;
  assign op_write_data = op_RegWrite ? r_data[r_rd_ptr] : '0;
  assign op_dest_reg   = op_RegWrite ? r_dest[r_rd_ptr] : '0;
  assign op_fwd_hit    = w_fwd_hit & ~reset;
  assign op_fwd_data   = reset ? '0 : w_fwd_data;
  assign op_count      = reset ? '0 : r_count;

endmodule

// File: tb/tb_write_back_buffered.sv
// Randomised and directed bench for write_back_buffered with a queue-based reference model and output scoreboard.
module tb_write_back_buffered;

  logic        clock = 1'b0;
  logic        reset;
  logic        ip_valid, ip_MemtoReg, ip_RegWrite, ip_load_signed, ip_rf_ready;
  logic [1:0]  ip_load_size;
  logic [31:0] ip_memory_data, ip_ALU_result;
  logic [4:0]  ip_dest_reg, ip_fwd_reg;
  logic        op_stall, op_RegWrite, op_fwd_hit;
  logic [31:0] op_write_data, op_fwd_data;
  logic [4:0]  op_dest_reg;
  logic [2:0]  op_count;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] dat;
  } ent_t;

  ent_t mdl_q[$];
  ent_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  write_back_buffered dut (
    .clock(clock), .reset(reset), .ip_valid(ip_valid), .ip_MemtoReg(ip_MemtoReg),
    .ip_RegWrite(ip_RegWrite), .ip_load_size(ip_load_size), .ip_load_signed(ip_load_signed),
    .ip_memory_data(ip_memory_data), .ip_ALU_result(ip_ALU_result), .ip_dest_reg(ip_dest_reg),
    .op_stall(op_stall), .ip_rf_ready(ip_rf_ready), .op_RegWrite(op_RegWrite),
    .op_write_data(op_write_data), .op_dest_reg(op_dest_reg), .ip_fwd_reg(ip_fwd_reg),
    .op_fwd_hit(op_fwd_hit), .op_fwd_data(op_fwd_data), .op_count(op_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic m2r, input logic [1:0] sz, input logic sg,
                                             input logic [31:0] mem, input logic [31:0] alu);
    if (!m2r) return alu;
    case (sz)
      2'b01:   return sg ? 32'(int'(shortint'(mem[15:0]))) : (mem & 32'h0000_FFFF);
      2'b10:   return sg ? 32'(int'(byte'(mem[7:0])))      : (mem & 32'h0000_00FF);
      default: return mem;
    endcase
  endfunction

  // Scoreboard monitor: every accepted head write must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && op_RegWrite && ip_rf_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_write", {27'b0, op_dest_reg}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_dest", {27'b0, op_dest_reg}, {27'b0, sb_q[0].dst});
        chk("sb_data", op_write_data, sb_q[0].dat);
        void'(sb_q.pop_front());
      end
    end
  end

  // Drive one cycle, compare combinational outputs with the model, then advance the model past the edge.
  task automatic step(input logic v, input logic m2r, input logic rw, input logic [1:0] sz,
                      input logic sg, input logic [31:0] mem, input logic [31:0] alu,
                      input logic [4:0] dst, input logic rdy, input logic [4:0] fwd, input logic rs);
    logic        hit;
    logic [31:0] fdat;
    int          n;
    bit          acc, deq;
    reset = rs; ip_valid = v; ip_MemtoReg = m2r; ip_RegWrite = rw; ip_load_size = sz;
    ip_load_signed = sg; ip_memory_data = mem; ip_ALU_result = alu; ip_dest_reg = dst;
    ip_rf_ready = rdy; ip_fwd_reg = fwd;
    #3;
    n = rs ? 0 : mdl_q.size();
    hit = 1'b0; fdat = '0;
    if (!rs && fwd != 0)
      for (int k = mdl_q.size() - 1; k >= 0; k--)
        if (mdl_q[k].dst == fwd) begin hit = 1'b1; fdat = mdl_q[k].dat; break; end
    chk("count", {29'b0, op_count}, n);
    chk("stall", {31'b0, op_stall}, {31'b0, n == 4});
    chk("regwrite", {31'b0, op_RegWrite}, {31'b0, n != 0});
    chk("fwd_hit", {31'b0, op_fwd_hit}, {31'b0, hit});
    chk("fwd_data", op_fwd_data, fdat);
    if (n == 0) begin
      chk("empty_data", op_write_data, 32'h0);
      chk("empty_dest", {27'b0, op_dest_reg}, 32'h0);
    end else begin
      chk("head_data", op_write_data, mdl_q[0].dat);
    end
    if (rs) begin
      mdl_q.delete();
      sb_q.delete();
    end else begin
      acc = v && rw && (n < 4) && (dst != 0);
      deq = (n != 0) && rdy;
      if (deq) void'(mdl_q.pop_front());
      if (acc) begin
        mdl_q.push_back('{dst, ref_result(m2r, sz, sg, mem, alu)});
        sb_q.push_back('{dst, ref_result(m2r, sz, sg, mem, alu)});
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [4:0] dst, input logic [31:0] alu, input logic rdy);
    step(1, 0, 1, 2'b00, 0, 32'h0, alu, dst, rdy, 5'd0, 0);
  endtask

  task automatic idle(input logic rdy, input logic [4:0] fwd);
    step(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, rdy, fwd, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && mdl_q.size() != 0; k++) idle(1, 5'd0);
    chk("drained", mdl_q.size(), 0);
  endtask

  logic [1:0]  ext_sz [5] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b10};
  logic        ext_sg [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic        ext_m2r[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] ext_exp[5] = '{32'hFFFF_80F0, 32'h0000_80F0, 32'hFFFF_FFF0, 32'h0000_80F0, 32'h1234_5678};

  initial begin
    reset = 1'b1; ip_valid = 0; ip_MemtoReg = 0; ip_RegWrite = 0; ip_load_size = 0;
    ip_load_signed = 0; ip_memory_data = 0; ip_ALU_result = 0; ip_dest_reg = 0;
    ip_rf_ready = 0; ip_fwd_reg = 0;
    @(posedge clock); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 5'd0);
    idle(1, 5'd3);

    for (int i = 0; i < 5; i++) begin
      step(1, ext_m2r[i], 1, ext_sz[i], ext_sg[i], 32'h0000_80F0, 32'h1234_5678, 5'd1, 0, 0, 0);
      chk("ext_result", op_write_data, ext_exp[i]);
      idle(1, 5'd0);
    end

    for (int i = 1; i <= 4; i++) wr(5'(i), 32'h11 * i, 0);
    chk("bp_stall_full", {31'b0, op_stall}, 32'h1);
    wr(5'd5, 32'h55, 0);
    chk("bp_count_after_refuse", {29'b0, op_count}, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("bp_order_dest", {27'b0, op_dest_reg}, i);
      chk("bp_order_data", op_write_data, 32'h11 * i);
      idle(1, 5'd0);
      if (i == 1) chk("bp_stall_drop", {31'b0, op_stall}, 32'h0);
    end

    wr(5'd3, 32'hA, 0); wr(5'd3, 32'hB, 0); wr(5'd7, 32'hC, 0);
    ip_fwd_reg = 5'd3; #1;
    chk("fwd_r3_hit", {31'b0, op_fwd_hit}, 32'h1);
    chk("fwd_r3_data", op_fwd_data, 32'hB);
    ip_fwd_reg = 5'd9; #1;
    chk("fwd_r9_hit", {31'b0, op_fwd_hit}, 32'h0);
    chk("fwd_r9_data", op_fwd_data, 32'h0);
    ip_fwd_reg = 5'd0; #1;
    chk("fwd_r0_hit", {31'b0, op_fwd_hit}, 32'h0);
    idle(0, 5'd7);
    drain();

    wr(5'd0, 32'hDEAD, 0);
    step(1, 0, 0, 0, 0, 0, 32'hBEEF, 5'd5, 0, 0, 0);
    chk("ignored_count", {29'b0, op_count}, 32'd0);
    chk("ignored_regwrite", {31'b0, op_RegWrite}, 32'h0);

    wr(5'd10, 32'h100, 0); wr(5'd11, 32'h101, 0);
    for (int i = 0; i < 10; i++) begin
      wr(5'(12 + i), 32'h200 + i, 1);
      chk("steady_count", {29'b0, op_count}, 32'd2);
    end
    drain();

    wr(5'd1, 32'h1, 0); wr(5'd2, 32'h2, 0); wr(5'd3, 32'h3, 0);
    idle(1, 5'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("reset_mid_regwrite", {31'b0, op_RegWrite}, 32'h0);
    chk("reset_mid_count", {29'b0, op_count}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 5) != 0, 2'($urandom),
           1'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 99) == 0);
    end
    drain();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
